// File: rtl/cardjitsu_input_conditioner_if.sv
// Signal bundle between the Card-Jitsu pad conditioner and its neighbours:
// raw pad inputs in, debounced levels and press/switch strobes out.
interface cardjitsu_input_conditioner_if;
    logic [2:0] btn_raw;
    logic [3:0] sw_raw;
    logic [2:0] btn_stable;
    logic       press_valid;
    logic [1:0] press_id;
    logic [3:0] sw_stable;
    logic       sw_changed;

    modport slave (
        input  btn_raw, sw_raw,
        output btn_stable, press_valid, press_id, sw_stable, sw_changed
    );

    modport master (
        output btn_raw, sw_raw,
        input  btn_stable, press_valid, press_id, sw_stable, sw_changed
    );
endinterface

// File: rtl/cardjitsu_input_conditioner.sv
// Card-Jitsu input front end: 2-flop sync, per-button and whole-vector switch debounce,
// single-ID press events. Optional auto-repeat behind CARDJITSU_AUTOREPEAT_EN.
module cardjitsu_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input logic                           clk,
    input logic                           rst_n,
    cardjitsu_input_conditioner_if.slave  cj
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_s1_q, btn_s2_q;
    logic [3:0]       sw_s1_q, sw_s2_q;
    logic [2:0]       btn_stable_q, btn_stable_d, btn_rise;
    logic [CNT_W-1:0] btn_cnt_q [3];
    logic [CNT_W-1:0] btn_cnt_d [3];
    logic [3:0]       sw_stable_q, sw_stable_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic             sw_changed_q, sw_changed_d;
    logic             press_valid_q, press_valid_d;
    logic [1:0]       press_id_q, press_id_d;
    logic             fresh_valid;
    logic [1:0]       fresh_id;

    always_comb begin
        btn_stable_d = btn_stable_q;
        btn_rise     = '0;
        for (int i = 0; i < 3; i++) begin
            btn_cnt_d[i] = '0;
            if (btn_s2_q[i] != btn_stable_q[i]) begin
                if (btn_cnt_q[i] == DB_LAST) begin
                    btn_stable_d[i] = btn_s2_q[i];
                    btn_rise[i]     = btn_s2_q[i];
                end else begin
                    btn_cnt_d[i] = btn_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lowest index wins when several buttons qualify on the same edge.
    always_comb begin
        fresh_valid = |btn_rise;
        if (btn_rise[0])      fresh_id = 2'd0;
        else if (btn_rise[1]) fresh_id = 2'd1;
        else                  fresh_id = 2'd2;
    end

    // s1 is the value s2 takes next cycle, so s1 != s2 flags a vector still in motion.
    always_comb begin
        sw_stable_d  = sw_stable_q;
        sw_cnt_d     = '0;
        sw_changed_d = 1'b0;
        if ((sw_s1_q == sw_s2_q) && (sw_s2_q != sw_stable_q)) begin
            if (sw_cnt_q == DB_LAST) begin
                sw_stable_d  = sw_s2_q;
                sw_changed_d = 1'b1;
            end else begin
                sw_cnt_d = sw_cnt_q + 1'b1;
            end
        end
    end

`ifdef CARDJITSU_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;
    logic [1:0]       rpt_id_q, rpt_id_d;
    logic             rpt_fire;

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_id_d    = rpt_id_q;
        rpt_fire    = 1'b0;
        if (fresh_valid) begin
            rpt_armed_d = 1'b1;
            rpt_id_d    = fresh_id;
            rpt_cnt_d   = RPT_W'(REPEAT_DELAY - 1);
        end else if (rpt_armed_q) begin
            if (!btn_stable_q[rpt_id_q]) begin
                rpt_armed_d = 1'b0;
                rpt_cnt_d   = '0;
            end else if (rpt_cnt_q == '0) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = RPT_W'(REPEAT_PERIOD - 1);
            end else begin
                rpt_cnt_d = rpt_cnt_q - 1'b1;
            end
        end
        press_valid_d = fresh_valid | rpt_fire;
        press_id_d    = fresh_valid ? fresh_id : (rpt_fire ? rpt_id_q : press_id_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
            rpt_id_q    <= '0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
            rpt_id_q    <= rpt_id_d;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};

    always_comb begin
        press_valid_d = fresh_valid;
        press_id_d    = fresh_valid ? fresh_id : press_id_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            btn_stable_q  <= '0;
            for (int i = 0; i < 3; i++) btn_cnt_q[i] <= '0;
            sw_stable_q   <= '0;
            sw_cnt_q      <= '0;
            sw_changed_q  <= 1'b0;
            press_valid_q <= 1'b0;
            press_id_q    <= '0;
        end else begin
            btn_s1_q      <= cj.btn_raw;
            btn_s2_q      <= btn_s1_q;
            sw_s1_q       <= cj.sw_raw;
            sw_s2_q       <= sw_s1_q;
            btn_stable_q  <= btn_stable_d;
            for (int i = 0; i < 3; i++) btn_cnt_q[i] <= btn_cnt_d[i];
            sw_stable_q   <= sw_stable_d;
            sw_cnt_q      <= sw_cnt_d;
            sw_changed_q  <= sw_changed_d;
            press_valid_q <= press_valid_d;
            press_id_q    <= press_id_d;
        end
    end

    assign cj.btn_stable  = btn_stable_q;
    assign cj.press_valid = press_valid_q;
    assign cj.press_id    = press_id_q;
    assign cj.sw_stable   = sw_stable_q;
    assign cj.sw_changed  = sw_changed_q;
endmodule

// File: tb/tb_cardjitsu_input_conditioner.sv
// Directed bench for cardjitsu_input_conditioner with DEBOUNCE_CYCLES=4; the
// auto-repeat scenario follows whichever way CARDJITSU_AUTOREPEAT_EN is set.
module tb_cardjitsu_input_conditioner;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cardjitsu_input_conditioner_if cj();

    cardjitsu_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cj(cj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic watch(input int n, output int pev, output int sev);
        pev = 0;
        sev = 0;
        for (int k = 0; k < n; k++) begin
            tick(1);
            if (cj.press_valid === 1'b1) pev++;
            if (cj.sw_changed === 1'b1) sev++;
        end
    endtask

    task automatic settle();
        int pev, sev;
        cj.btn_raw = 3'b000;
        watch(10, pev, sev);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cj.btn_raw = 3'b000;
        cj.sw_raw  = 4'b0000;
        tick(2);
        checks++; if (cj.btn_stable !== 3'b000) begin failures++; $display("FAIL reset_btn_stable got=%b exp=000", cj.btn_stable); end
        checks++; if (cj.press_valid !== 1'b0) begin failures++; $display("FAIL reset_press_valid got=%b exp=0", cj.press_valid); end
        checks++; if (cj.press_id !== 2'd0) begin failures++; $display("FAIL reset_press_id got=%0d exp=0", cj.press_id); end
        checks++; if (cj.sw_stable !== 4'b0000) begin failures++; $display("FAIL reset_sw_stable got=%b exp=0000", cj.sw_stable); end
        checks++; if (cj.sw_changed !== 1'b0) begin failures++; $display("FAIL reset_sw_changed got=%b exp=0", cj.sw_changed); end
        #4 rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_clean_press();
        int pev, sev;
        cj.btn_raw = 3'b010;
        tick(5);
        checks++; if (cj.btn_stable !== 3'b000) begin failures++; $display("FAIL clean_early_stable got=%b exp=000", cj.btn_stable); end
        checks++; if (cj.press_valid !== 1'b0) begin failures++; $display("FAIL clean_early_valid got=%b exp=0", cj.press_valid); end
        tick(1);
        checks++; if (cj.btn_stable !== 3'b010) begin failures++; $display("FAIL clean_stable got=%b exp=010", cj.btn_stable); end
        checks++; if (cj.press_valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", cj.press_valid); end
        checks++; if (cj.press_id !== 2'd1) begin failures++; $display("FAIL clean_id got=%0d exp=1", cj.press_id); end
        tick(1);
        checks++; if (cj.press_valid !== 1'b0) begin failures++; $display("FAIL clean_valid_drop got=%b exp=0", cj.press_valid); end
        watch(10, pev, sev);
        checks++; if (pev !== 0) begin failures++; $display("FAIL clean_hold_events got=%0d exp=0", pev); end
        cj.btn_raw = 3'b000;
        watch(8, pev, sev);
        checks++; if (pev !== 0) begin failures++; $display("FAIL clean_release_events got=%0d exp=0", pev); end
        checks++; if (cj.btn_stable !== 3'b000) begin failures++; $display("FAIL clean_release_stable got=%b exp=000", cj.btn_stable); end
    endtask

    task automatic test_bounce();
        int pev, sev, total;
        total = 0;
        for (int k = 0; k < 6; k++) begin
            cj.btn_raw = (k % 2 == 0) ? 3'b001 : 3'b000;
            watch(1, pev, sev);
            total += pev;
        end
        cj.btn_raw = 3'b001;
        watch(5, pev, sev);
        total += pev;
        checks++; if (total !== 0) begin failures++; $display("FAIL bounce_events_early got=%0d exp=0", total); end
        tick(1);
        checks++; if (cj.press_valid !== 1'b1) begin failures++; $display("FAIL bounce_valid got=%b exp=1", cj.press_valid); end
        checks++; if (cj.press_id !== 2'd0) begin failures++; $display("FAIL bounce_id got=%0d exp=0", cj.press_id); end
        watch(10, pev, sev);
        checks++; if (pev !== 0) begin failures++; $display("FAIL bounce_extra_events got=%0d exp=0", pev); end
        settle();
    endtask

    task automatic test_simultaneous();
        int pev, sev;
        cj.btn_raw = 3'b101;
        watch(5, pev, sev);
        checks++; if (pev !== 0) begin failures++; $display("FAIL simul_early_events got=%0d exp=0", pev); end
        tick(1);
        checks++; if (cj.press_valid !== 1'b1) begin failures++; $display("FAIL simul_valid got=%b exp=1", cj.press_valid); end
        checks++; if (cj.press_id !== 2'd0) begin failures++; $display("FAIL simul_id got=%0d exp=0", cj.press_id); end
        checks++; if (cj.btn_stable !== 3'b101) begin failures++; $display("FAIL simul_stable got=%b exp=101", cj.btn_stable); end
        watch(10, pev, sev);
        checks++; if (pev !== 0) begin failures++; $display("FAIL simul_late_events got=%0d exp=0", pev); end
        cj.btn_raw = 3'b000;
        watch(5, pev, sev);
        checks++; if (cj.btn_stable !== 3'b101) begin failures++; $display("FAIL simul_rel_early got=%b exp=101", cj.btn_stable); end
        tick(1);
        checks++; if (cj.btn_stable !== 3'b000) begin failures++; $display("FAIL simul_rel_stable got=%b exp=000", cj.btn_stable); end
        watch(5, sev, pev);
        checks++; if (sev !== 0) begin failures++; $display("FAIL simul_rel_events got=%0d exp=0", sev); end
    endtask

    task automatic test_switches();
        int pev, sev;
        cj.sw_raw = 4'b1010;
        tick(5);
        checks++; if (cj.sw_stable !== 4'b0000) begin failures++; $display("FAIL sw_early_stable got=%b exp=0000", cj.sw_stable); end
        checks++; if (cj.sw_changed !== 1'b0) begin failures++; $display("FAIL sw_early_changed got=%b exp=0", cj.sw_changed); end
        tick(1);
        checks++; if (cj.sw_stable !== 4'b1010) begin failures++; $display("FAIL sw_stable got=%b exp=1010", cj.sw_stable); end
        checks++; if (cj.sw_changed !== 1'b1) begin failures++; $display("FAIL sw_changed got=%b exp=1", cj.sw_changed); end
        tick(1);
        checks++; if (cj.sw_changed !== 1'b0) begin failures++; $display("FAIL sw_changed_drop got=%b exp=0", cj.sw_changed); end
        cj.sw_raw = 4'b1110;
        tick(2);
        cj.sw_raw = 4'b1010;
        watch(10, pev, sev);
        checks++; if (sev !== 0) begin failures++; $display("FAIL sw_blip_strobes got=%0d exp=0", sev); end
        checks++; if (cj.sw_stable !== 4'b1010) begin failures++; $display("FAIL sw_blip_stable got=%b exp=1010", cj.sw_stable); end
    endtask

    task automatic test_reset_mid();
        int pev, sev;
        cj.btn_raw = 3'b100;
        tick(4);
        rst_n = 1'b0;
        #1;
        checks++; if (cj.btn_stable !== 3'b000) begin failures++; $display("FAIL rmid_btn_stable got=%b exp=000", cj.btn_stable); end
        checks++; if (cj.sw_stable !== 4'b0000) begin failures++; $display("FAIL rmid_sw_stable got=%b exp=0000", cj.sw_stable); end
        checks++; if (cj.press_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", cj.press_valid); end
        #3 rst_n = 1'b1;
        watch(5, pev, sev);
        checks++; if (pev !== 0) begin failures++; $display("FAIL rmid_early_events got=%0d exp=0", pev); end
        tick(1);
        checks++; if (cj.press_valid !== 1'b1) begin failures++; $display("FAIL rmid_valid_event got=%b exp=1", cj.press_valid); end
        checks++; if (cj.press_id !== 2'd2) begin failures++; $display("FAIL rmid_id got=%0d exp=2", cj.press_id); end
        checks++; if (cj.sw_stable !== 4'b1010) begin failures++; $display("FAIL rmid_sw_reload got=%b exp=1010", cj.sw_stable); end
        settle();
    endtask

    task automatic test_repeat();
        int pev, sev;
`ifdef CARDJITSU_AUTOREPEAT_EN
        logic exp_v;
        cj.btn_raw = 3'b010;
        for (int e = 0; e < 25; e++) begin
            tick(1);
            exp_v = (e == 5) || (e >= 13 && ((e - 13) % 3) == 0);
            checks++; if (cj.press_valid !== exp_v) begin failures++; $display("FAIL repeat_edge%0d got=%b exp=%b", e, cj.press_valid, exp_v); end
            if (exp_v) begin
                checks++; if (cj.press_id !== 2'd1) begin failures++; $display("FAIL repeat_id_edge%0d got=%0d exp=1", e, cj.press_id); end
            end
        end
        cj.btn_raw = 3'b000;
        tick(6);
        checks++; if (cj.btn_stable !== 3'b000) begin failures++; $display("FAIL repeat_rel_stable got=%b exp=000", cj.btn_stable); end
        watch(12, pev, sev);
        checks++; if (pev !== 0) begin failures++; $display("FAIL repeat_after_release got=%0d exp=0", pev); end
`else
        cj.btn_raw = 3'b010;
        watch(30, pev, sev);
        checks++; if (pev !== 1) begin failures++; $display("FAIL norepeat_events got=%0d exp=1", pev); end
        settle();
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_switches();
        test_reset_mid();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
